// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int AES128_ROUNDS = 10;
  localparam int ROUND_IDX_W   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    int   c;
    logic found;
    c     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(ptr_i) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/aes_round_sched.sv
// Round sequencer and requester arbiter for the shared iterative AES-128 round datapath.
module aes_round_sched
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_decrypt,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  input  logic                         abort,
  output logic                         dp_load,
  output logic [$clog2(NUM_REQ)-1:0]   dp_sel,
  output logic [ROUND_IDX_W-1:0]       dp_round,
  output logic                         dp_final,
  output logic                         dp_decrypt,
  output logic                         dp_capture,
  output logic                         busy
);

  localparam int SW = $clog2(NUM_REQ);
  localparam logic [ROUND_IDX_W-1:0] LAST_RND = ROUND_IDX_W'(NUM_ROUNDS);

  sched_state_e            state_q;
  logic [SW-1:0]           grant_q;
  logic [SW-1:0]           ptr_q;
  logic [SW-1:0]           ptr_d;
  logic                    dec_q;
  logic                    cap_q;
  logic [ROUND_IDX_W-1:0]  cnt_q;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [SW-1:0]           arb_idx;
  logic                    arb_any;
  logic [NUM_REQ-1:0]      grant_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign ptr_d    = (grant_q == SW'(NUM_REQ - 1)) ? '0 : grant_q + SW'(1);
  assign grant_oh = NUM_REQ'(1) << grant_q;

  // cnt_q counts ROUND cycles 1..NUM_ROUNDS and holds at the terminal value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      dec_q   <= 1'b0;
      cap_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cap_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_idx;
            dec_q   <= |(req_decrypt & arb_gnt);
            cnt_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else begin
            cnt_q   <= ROUND_IDX_W'(1);
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else if (cnt_q == LAST_RND) begin
            cap_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + ROUND_IDX_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready[grant_q]) begin
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign dp_load    = (state_q == LOAD);
  assign req_ready  = (state_q == LOAD) ? grant_oh : '0;
  assign rsp_valid  = (state_q == DONE) ? grant_oh : '0;
  assign dp_capture = cap_q;
  assign dp_sel     = grant_q;
  assign dp_decrypt = dec_q;
  assign dp_final   = (state_q == ROUND) && (cnt_q == LAST_RND);
  // Decrypt walks the key schedule backwards from the last round key.
  assign dp_round   = ((state_q == LOAD) || (state_q == ROUND)) ?
                      (dec_q ? (LAST_RND - cnt_q) : cnt_q) : '0;

endmodule
